// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Parametrised multi-read-port integer register file. Writes are
//             clocked and x0 is hardwired to zero. A sequential clear sweep
//             zeroes x1..x(NREGS-1) after reset or on clear_req. While the
//             sweep runs, all reads return 0 and writes are dropped, with a
//             one-cycle wr_drop pulse per dropped write.
//  Config   : `define REGFILE_BYPASS_EN compiles in a write-through bypass.
//             A READY-state write is then visible on the read ports in the
//             same cycle. Undefined (the default): 1-cycle write-to-read.
//  Ports    : clk       - rising-edge clock
//             rst_n     - synchronous active-low reset (starts a sweep)
//             clear_req - start a clear sweep (honoured only in READY)
//             ready     - array valid, writes accepted
//             rd_addr   - NREAD packed read addresses, port p at [p*AW +: AW]
//             rd_data   - NREAD packed read data, port p at [p*XLEN +: XLEN]
//             we        - write enable
//             wr_addr   - write address
//             wr_data   - write data
//             wr_drop   - registered pulse: a write was discarded in CLEAR
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  output logic                    ready,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  input  logic                    we,
  input  logic [AW-1:0]           wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  output logic                    wr_drop
);

  localparam logic [0:0]    S_CLEAR    = 1'b0;
  localparam logic [0:0]    S_READY    = 1'b1;
  localparam logic [AW-1:0] c_FIRST    = AW'(1);
  localparam logic [AW-1:0] c_LAST_PTR = AW'(NREGS - 1);

  // x0 has no storage: entries 1..NREGS-1 only.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic          r_wr_drop;
  logic          w_ready;
  logic          w_sweep_we;
  logic          w_wr_en;

  // --------------------------------------------------------------------------
  // FSM: state register (also carries the sweep pointer and drop flag)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_ptr     <= c_FIRST;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_wr_drop <= (r_state == S_CLEAR) && we;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_CLEAR: begin
        // clear_req is deliberately ignored here so a sweep is never restarted.
        w_ptr_nxt = r_ptr + AW'(1);
        if (r_ptr == c_LAST_PTR) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (clear_req) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = c_FIRST;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_ptr_nxt   = c_FIRST;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_ready    = (r_state == S_READY);
    w_sweep_we = rst_n && (r_state == S_CLEAR);
    // The write on the clear_req edge is still performed (state is READY).
    w_wr_en    = rst_n && (r_state == S_READY) && we && (wr_addr != '0);
  end

  assign ready   = w_ready;
  assign wr_drop = r_wr_drop;

  // --------------------------------------------------------------------------
  // Storage: no reset, contents only change via sweep or accepted writes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_regs[r_ptr] <= '0;
    end else if (w_wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;

    assign w_addr = rd_addr[p*AW +: AW];

    always_comb begin
      w_data = '0;
      if (w_ready && (w_addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (wr_addr == w_addr)) begin
          w_data = wr_data;
        end else begin
          w_data = r_regs[w_addr];
        end
`else
        w_data = r_regs[w_addr];
`endif
      end
    end

    assign rd_data[p*XLEN +: XLEN] = w_data;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RISC-V core. It replaces the fixed 32×32, two-read, combinational-write register file. Writes are clocked; register 0 is hardwired to zero. A sequential clear sweep zeroes the array after reset or on request. The decode stage reads operands and the writeback stage writes results.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of registers. Must be a power of two and ≥ 2. Derived address width AW = $clog2(NREGS).
- NREAD, 2: number of read ports, ≥ 1.

- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- clear_req  input  1  start a clear sweep; honoured only in READY.
- ready  output  1  high when the array is valid and writes are accepted.
- rd_addr  input  NREAD*AW  read addresses; port p occupies bits [p*AW +: AW].
- rd_data  output  NREAD*XLEN  read data; port p occupies bits [p*XLEN +: XLEN].
- we  input  1  write enable (RegWrite).
- wr_addr  input  AW  write address (Rd).
- wr_data  input  XLEN  write data (Result).
- wr_drop  output  1  registered pulse: a write with we=1 was discarded during CLEAR.

## Operation
- **Storage:** array reg[1..NREGS-1] of XLEN bits. reg[0] is not stored and always reads 0.
- **FSM states:** CLEAR and READY.
  - rst_n low at a rising edge → state=CLEAR, ptr=1, wr_drop=0. The array contents are not touched by reset itself.
  - CLEAR: each edge with rst_n high writes reg[ptr]=0 and then increments ptr. On the edge that clears ptr==NREGS-1, state→READY.
  - READY: clear_req=1 at an edge → state=CLEAR, ptr=1. The write presented on that same edge is still performed.
  - clear_req is ignored in CLEAR; it does not restart the sweep.
- **Writes:** in READY, we=1 and wr_addr≠0 at an edge → reg[wr_addr]=wr_data. A write to address 0 is discarded silently; wr_drop stays 0.
- **Writes in CLEAR:** we=1 at an edge in CLEAR is discarded and wr_drop=1 on the next cycle. Otherwise wr_drop=0.
- **Reads:** combinational. rd_data[p] = 0 if rd_addr[p]==0 or state==CLEAR; otherwise reg[rd_addr[p]], plus the bypass described under Configuration.
- Any number of read ports may address the same register.
- Reset asserted mid-sweep restarts the sweep from ptr=1 on the following edges.

## Timing
- **Reset values:** ready=0, wr_drop=0, rd_data=0 on every port (state CLEAR).
- **Sweep length:** NREGS-1 edges with rst_n high. After rst_n rises, ready=1 following the (NREGS-1)th rising edge. For defaults this is 31 cycles.
- **Write-to-read latency:** 1 cycle without bypass. Data written at edge k is visible on rd_data after edge k.
- **clear_req response:** ready falls the cycle after the edge that samples clear_req=1.
- **wr_drop:** asserts exactly one cycle after the offending edge and lasts one cycle per dropped write.

## Configuration
- **REGFILE_BYPASS_EN defined:** a write-through bypass is compiled in. In READY, if we=1, wr_addr≠0 and rd_addr[p]==wr_addr, then rd_data[p]=wr_data in the same cycle (0-cycle write-to-read). The bypass is inactive in CLEAR.
- **REGFILE_BYPASS_EN not defined:** no bypass. rd_data[p] shows the old contents until the write edge.

## Test plan
- **Reset and sweep:** hold rst_n=0 for 2 edges, release, poll ready → ready=0 for exactly 31 edges, then 1. All rd_data are 0 throughout. With defaults, every register then reads 0x00000000.
- **Write/read:** write 0xDEADBEEF to x5 and 0x12345678 to x31, then read x5 on port 0 and x31 on port 1 → 0xDEADBEEF and 0x12345678. Both ports reading x5 → both 0xDEADBEEF.
- **Zero register:** write 0xFFFFFFFF to x0, read x0 → 0x00000000; wr_drop stays 0.
- **Clear request:** fill x1..x31 with nonzero data, pulse clear_req → ready=0 next cycle. A write of 0xAA to x3 presented 2 cycles later is dropped with a wr_drop pulse. After 31 cycles ready=1 and x3 reads 0.
- **Reset mid-sweep:** assert rst_n=0 for 1 edge when ptr=10, release → ready=1 after a further full 31 edges.
- **Bypass:** write 0xCAFEF00D to x7 while reading x7 in the same cycle (old value 0x1). With REGFILE_BYPASS_EN the read returns 0xCAFEF00D; without it the read returns 0x00000001, and 0xCAFEF00D appears the next cycle.
